program_memory_arbiter: RTL

- Shares the single combinational read port of the instruction ROM between two requesters: instruction fetch (F) and a data-side read port (D).
- D serves loads from .text, e.g. constant tables or a debug/readback path.
- Performs request/grant arbitration, TEXT_BASE offset removal, alignment and range checking, and returns a registered read response one cycle after grant.
- Sits between the PC/fetch stage and the ROM, and between the load path and the ROM.

---
 rtl/program_memory_arbiter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/program_memory_arbiter.sv
// ---------------------------------------------------------------------------
// program_memory_arbiter
//
// Purpose:
//   Shares the single combinational read port of the instruction ROM between
//   the instruction fetch requester (F) and a data-side read requester (D).
//   Each cycle at most one requester is granted. When both request, the one
//   that did not win last time is chosen (round robin). The granted byte
//   address has TEXT_BASE removed before it reaches the ROM. It is checked
//   for alignment and range, and the read data (or an error) is returned as
//   a registered one-cycle pulse on the edge after the grant.
//
// Ports:
//   clk          : system clock, rising edge
//   reset        : synchronous reset, active low
//   f_req_i      : fetch request, held together with f_addr_i until granted
//   f_addr_i     : fetch byte address
//   f_gnt_o      : fetch grant, combinational, valid this cycle
//   f_rvalid_o   : fetch response valid, one-cycle pulse
//   f_rdata_o    : fetch response data (0 on error)
//   f_err_o      : fetch response error, qualified by f_rvalid_o
//   d_req_i      : data request
//   d_addr_i     : data byte address
//   d_gnt_o      : data grant
//   d_rvalid_o   : data response valid
//   d_rdata_o    : data response data (0 on error)
//   d_err_o      : data response error
//   mem_addr_o   : offset-corrected byte address to the ROM
//   mem_instr_i  : combinational ROM read data
//
// Optional feature (macro PM_ARB_PERF_CNT_EN):
//   conflict_cnt_o [15:0] : saturating count of cycles where both requested
//   err_cnt_o      [7:0]  : saturating count of errored grants
// ---------------------------------------------------------------------------
module program_memory_arbiter #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = 'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req_i,
  input  logic [DATA_WIDTH-1:0] f_addr_i,
  output logic                  f_gnt_o,
  output logic                  f_rvalid_o,
  output logic [DATA_WIDTH-1:0] f_rdata_o,
  output logic                  f_err_o,
  input  logic                  d_req_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_err_o,
`ifdef PM_ARB_PERF_CNT_EN
  output logic [15:0]           conflict_cnt_o,
  output logic [7:0]            err_cnt_o,
`endif
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_instr_i
);

  // Word count widened to the address width so the range compare is
  // between operands of equal width.
  localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEMORY_DEPTH);

  // Round-robin pointer: remembers which requester won most recently.
  typedef enum logic {
    LAST_F = 1'b0,
    LAST_D = 1'b1
  } last_e;

  last_e                 r_last;
  last_e                 w_lastNext;

  logic                  w_fGnt;
  logic                  w_dGnt;
  logic                  w_anyGnt;

  logic [DATA_WIDTH-1:0] w_fOff;
  logic [DATA_WIDTH-1:0] w_dOff;
  logic                  w_fErr;
  logic                  w_dErr;
  logic [DATA_WIDTH-1:0] w_selOff;
  logic                  w_selErr;

  logic                  r_fRvalid;
  logic [DATA_WIDTH-1:0] r_fRdata;
  logic                  r_fErr;
  logic                  r_dRvalid;
  logic [DATA_WIDTH-1:0] r_dRdata;
  logic                  r_dErr;

  // A byte offset is bad when it is not word aligned or when its word index
  // falls past the end of the ROM. Addresses below TEXT_BASE wrap around to
  // huge offsets and therefore fail the range test as well.
  function automatic logic addrErr(input logic [DATA_WIDTH-1:0] off);
    logic misaligned;
    logic outOfRange;
    misaligned = (off[1:0] != 2'b00);
    outOfRange = ({2'b00, off[DATA_WIDTH-1:2]} >= DEPTH_W);
    return misaligned || outOfRange;
  endfunction

  // Offset removal is plain modular subtraction.
  always_comb begin
    w_fOff = f_addr_i - TEXT_BASE;
    w_dOff = d_addr_i - TEXT_BASE;
    w_fErr = addrErr(w_fOff);
    w_dErr = addrErr(w_dOff);
  end

  // Round-robin pointer register. After reset it points at D so that F
  // wins the very first conflict.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= LAST_D;
    end else begin
      r_last <= w_lastNext;
    end
  end

  // Grant decision and next pointer value. No grant is issued while reset
  // is held low, so nothing can be accepted that would be dropped anyway.
  always_comb begin
    w_fGnt     = 1'b0;
    w_dGnt     = 1'b0;
    w_lastNext = r_last;
    if (reset) begin
      if (f_req_i && d_req_i) begin
        if (r_last == LAST_D) begin
          w_fGnt = 1'b1;
        end else begin
          w_dGnt = 1'b1;
        end
      end else if (f_req_i) begin
        w_fGnt = 1'b1;
      end else if (d_req_i) begin
        w_dGnt = 1'b1;
      end

      if (w_fGnt) begin
        w_lastNext = LAST_F;
      end else if (w_dGnt) begin
        w_lastNext = LAST_D;
      end
    end
  end

  // ROM address mux. Only a clean granted request drives a real address;
  // idle cycles and errored requests present word 0 to the ROM.
  always_comb begin
    w_anyGnt = w_fGnt || w_dGnt;
    w_selOff = w_dGnt ? w_dOff : w_fOff;
    w_selErr = w_dGnt ? w_dErr : w_fErr;
    mem_addr_o = '0;
    if (w_anyGnt && !w_selErr) begin
      mem_addr_o = w_selOff;
    end
  end

  // Fetch response register. rvalid pulses for exactly the cycle after a
  // grant; data and error hold their last values between responses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fRvalid <= 1'b0;
      r_fRdata  <= '0;
      r_fErr    <= 1'b0;
    end else begin
      r_fRvalid <= w_fGnt;
      if (w_fGnt) begin
        r_fErr   <= w_fErr;
        r_fRdata <= w_fErr ? '0 : mem_instr_i;
      end
    end
  end

  // Data response register, same behaviour as the fetch side.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dRvalid <= 1'b0;
      r_dRdata  <= '0;
      r_dErr    <= 1'b0;
    end else begin
      r_dRvalid <= w_dGnt;
      if (w_dGnt) begin
        r_dErr   <= w_dErr;
        r_dRdata <= w_dErr ? '0 : mem_instr_i;
      end
    end
  end

`ifdef PM_ARB_PERF_CNT_EN
  logic [15:0] r_conflictCnt;
  logic [7:0]  r_errCnt;
  logic        w_errGnt;

  assign w_errGnt = (w_fGnt && w_fErr) || (w_dGnt && w_dErr);

  // Saturating counters: a conflict is any cycle with both requests high,
  // whether or not either side is later withdrawn.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_conflictCnt <= '0;
      r_errCnt      <= '0;
    end else begin
      if (f_req_i && d_req_i && (r_conflictCnt != 16'hFFFF)) begin
        r_conflictCnt <= r_conflictCnt + 16'd1;
      end
      if (w_errGnt && (r_errCnt != 8'hFF)) begin
        r_errCnt <= r_errCnt + 8'd1;
      end
    end
  end

  assign conflict_cnt_o = r_conflictCnt;
  assign err_cnt_o      = r_errCnt;
`endif

  assign f_gnt_o    = w_fGnt;
  assign d_gnt_o    = w_dGnt;
  assign f_rvalid_o = r_fRvalid;
  assign f_rdata_o  = r_fRdata;
  assign f_err_o    = r_fErr;
  assign d_rvalid_o = r_dRvalid;
  assign d_rdata_o  = r_dRdata;
  assign d_err_o    = r_dErr;

endmodule
